branch_resolve_unit: RTL and testbench

//  Sits directly downstream of the global history predictor. Captures each decode-stage prediction
//  and predicted target in an in-order FIFO, and resolves it against the actual outcome at the
//  MEM stage. On a mispredict it issues a redirect PC and a multi-cycle pipeline flush.

---
 rtl/branch_resolve_unit_if.sv | 38 +++
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 tb/tb_branch_resolve_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bus between the decode/MEM stages and the branch resolve unit.
//   master: decode push (branch_decode_sig, prediction, pred_target, pc_fallthrough)
//           and MEM resolve (branch_mem_sig, actual_branch_decision)
//   slave : redirect (mispredict, redirect_pc, flush), FIFO status and error flags,
//           performance counters (branch_cnt, mispredict_cnt)
interface branch_resolve_unit_if #(
    parameter int CNT_W = 16
);
    logic             branch_decode_sig;
    logic             prediction;
    logic [31:0]      pred_target;
    logic [31:0]      pc_fallthrough;
    logic             branch_mem_sig;
    logic             actual_branch_decision;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow_err;
    logic             underflow_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output branch_decode_sig, prediction, pred_target, pc_fallthrough,
               branch_mem_sig, actual_branch_decision,
        input  mispredict, redirect_pc, flush, fifo_full, fifo_empty,
               overflow_err, underflow_err, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  branch_decode_sig, prediction, pred_target, pc_fallthrough,
               branch_mem_sig, actual_branch_decision,
        output mispredict, redirect_pc, flush, fifo_full, fifo_empty,
               overflow_err, underflow_err, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit. Queues each decode-stage prediction in an in-order FIFO and
// checks it against the real outcome when the branch reaches MEM. A mispredict
// produces a one-cycle redirect pulse, a FLUSH_CYC-cycle flush, and empties the FIFO.
// Ports:
//   clk   - core clock
//   rst_n - synchronous active-low reset
//   bus   - branch_resolve_unit_if.slave (push/resolve inputs, redirect/status outputs)
module branch_resolve_unit #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef struct packed {
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] ft;
    } entry_t;

    typedef enum logic {RUN, FLUSH} state_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    state_t           state;
    logic [FW-1:0]    flush_cnt;
    logic [CNT_W-1:0] branch_cnt_q, mis_cnt_q;

    logic   full, empty, run, do_pop, do_push, mis;
    entry_t head;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign run   = (state == RUN);
    assign head  = mem[rd_ptr];

    assign do_pop  = bus.branch_mem_sig && run && !empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign do_push = bus.branch_decode_sig && run && (!full || do_pop);
    assign mis     = do_pop && (head.pred != bus.actual_branch_decision);

    assign bus.fifo_full      = full;
    assign bus.fifo_empty     = empty;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mis_cnt_q;

    // Storage needs no reset: count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= '{pred: bus.prediction, tgt: bus.pred_target, ft: bus.pc_fallthrough};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            state             <= RUN;
            flush_cnt         <= '0;
            bus.mispredict    <= 1'b0;
            bus.redirect_pc   <= '0;
            bus.flush         <= 1'b0;
            bus.overflow_err  <= 1'b0;
            bus.underflow_err <= 1'b0;
            branch_cnt_q      <= '0;
            mis_cnt_q         <= '0;
        end else begin
            bus.mispredict <= mis;
            case (state)
                RUN: begin
                    if (bus.branch_decode_sig && full && !do_pop)
                        bus.overflow_err <= 1'b1;
                    if (bus.branch_mem_sig && empty)
                        bus.underflow_err <= 1'b1;

                    if (do_pop) begin
                        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
                        if (mis && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
                    end

                    if (mis) begin
                        // Everything younger is wrong-path, including a same-cycle push.
                        bus.redirect_pc <= bus.actual_branch_decision ? head.tgt : head.ft;
                        wr_ptr          <= '0;
                        rd_ptr          <= '0;
                        count           <= '0;
                        state           <= FLUSH;
                        flush_cnt       <= FW'(FLUSH_CYC - 1);
                        bus.flush       <= 1'b1;
                    end else begin
                        if (do_push) wr_ptr <= wr_ptr + 1'b1;
                        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                        count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state     <= RUN;
                        bus.flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.CNT_W(16)) bus ();
    branch_resolve_unit_if #(.CNT_W(4))  sbus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // Narrow-counter instance so counter saturation is reachable in a short run.
    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    ent_t        mq[$];
    logic        sb_q[$];   // expected mispredict per resolve, consumed when DUT responds
    int          m_fl;
    logic [15:0] m_bc, m_mc;
    logic        m_ovf, m_udf;
    logic [31:0] m_rpc;

    task automatic step(input logic rst, input logic dec, input logic pred,
                        input logic [31:0] tgt, input logic [31:0] ft,
                        input logic mem, input logic act);
        logic pop_ok, push_ok, mis, exp_mis;
        ent_t e;
        rst_n                      = rst;
        bus.branch_decode_sig      = dec;
        bus.prediction             = pred;
        bus.pred_target            = tgt;
        bus.pc_fallthrough         = ft;
        bus.branch_mem_sig         = mem;
        bus.actual_branch_decision = act;
        @(posedge clk);
        if (!rst) begin
            mq.delete(); sb_q.delete();
            m_fl = 0; m_bc = '0; m_mc = '0; m_ovf = 1'b0; m_udf = 1'b0; m_rpc = '0;
        end else if (m_fl > 0) begin
            m_fl--;
        end else begin
            pop_ok  = mem && (mq.size() > 0);
            push_ok = dec && ((mq.size() < DEPTH) || pop_ok);
            if (dec && !push_ok) m_ovf = 1'b1;
            if (mem && mq.size() == 0) m_udf = 1'b1;
            mis = 1'b0;
            if (pop_ok) begin
                e   = mq.pop_front();
                mis = (e.pred != act);
                sb_q.push_back(mis);
                if (m_bc != 16'hFFFF) m_bc++;
                if (mis && m_mc != 16'hFFFF) m_mc++;
                if (mis) begin
                    m_rpc = act ? e.tgt : e.ft;
                    mq.delete();
                    m_fl = FLUSH_CYC;
                end
            end
            if (push_ok && !mis) mq.push_back('{pred, tgt, ft});
        end
        @(negedge clk);
        exp_mis = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
        chk("mispredict",     32'(bus.mispredict),     32'(exp_mis));
        chk("redirect_pc",    bus.redirect_pc,         m_rpc);
        chk("flush",          32'(bus.flush),          32'(m_fl > 0));
        chk("fifo_empty",     32'(bus.fifo_empty),     32'(mq.size() == 0));
        chk("fifo_full",      32'(bus.fifo_full),      32'(mq.size() == DEPTH));
        chk("overflow_err",   32'(bus.overflow_err),   32'(m_ovf));
        chk("underflow_err",  32'(bus.underflow_err),  32'(m_udf));
        chk("branch_cnt",     32'(bus.branch_cnt),     32'(m_bc));
        chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_mc));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic push(input logic p, input logic [31:0] t, input logic [31:0] f);
        step(1'b1, 1'b1, p, t, f, 1'b0, 1'b0);
    endtask
    task automatic pop(input logic a);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, a);
    endtask

    task automatic sat_cyc(input logic dec, input logic pred, input logic mem, input logic act);
        sbus.branch_decode_sig      = dec;
        sbus.prediction             = pred;
        sbus.pred_target            = 32'h1000;
        sbus.pc_fallthrough         = 32'h2000;
        sbus.branch_mem_sig         = mem;
        sbus.actual_branch_decision = act;
        @(negedge clk);
    endtask

    initial begin
        sbus.branch_decode_sig = 1'b0; sbus.prediction = 1'b0;
        sbus.pred_target = '0; sbus.pc_fallthrough = '0;
        sbus.branch_mem_sig = 1'b0; sbus.actual_branch_decision = 1'b0;
        rst_n = 1'b0;
        bus.branch_decode_sig = 1'b0; bus.prediction = 1'b0;
        bus.pred_target = '0; bus.pc_fallthrough = '0;
        bus.branch_mem_sig = 1'b0; bus.actual_branch_decision = 1'b0;
        @(negedge clk);

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(); idle();

        // Correct prediction
        push(1'b1, 32'h100, 32'h20);
        pop(1'b1);

        // Mispredict: redirect to target, younger entry squashed
        push(1'b0, 32'h200, 32'h44);
        push(1'b1, 32'h300, 32'h48);
        pop(1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b0);  // ignored during flush
        idle(); idle();

        // Fill, overflow, push+pop at full, drain
        for (int i = 0; i < DEPTH; i++) push(1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        push(1'b1, 32'h1fff, 32'h2fff);
        step(1'b1, 1'b1, 1'b1, 32'h1100, 32'h2100, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop(1'b1);

        // Underflow is sticky; reset clears it
        pop(1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle();

        // Mispredict not-taken -> fallthrough; reset during flush
        push(1'b1, 32'h500, 32'h504);
        pop(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        push(1'b0, 32'h600, 32'h604);
        pop(1'b0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Saturation on the 4-bit counter instance
        for (int i = 0; i < 20; i++) begin
            sat_cyc(1'b1, 1'b0, 1'b0, 1'b0);
            sat_cyc(1'b0, 1'b0, 1'b1, 1'b1);
            sat_cyc(1'b0, 1'b0, 1'b0, 1'b0);
            sat_cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_branch_cnt",     32'(sbus.branch_cnt),     32'hF);
        chk("sat_mispredict_cnt", 32'(sbus.mispredict_cnt), 32'hF);
        sat_cyc(1'b1, 1'b1, 1'b0, 1'b0);
        sat_cyc(1'b0, 1'b0, 1'b1, 1'b1);
        sat_cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_branch_hold",   32'(sbus.branch_cnt),     32'hF);
        chk("sat_no_mispredict", 32'(sbus.mispredict),     32'h0);
        chk("sat_mis_hold",      32'(sbus.mispredict_cnt), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
